// File: rtl/coeffs_load_sequencer.sv
// Coefficient reload sequencer: streams NUM_COEFFS beats into the FIR coefficient bank write port
// and issues the shadow-bank commit only at a safe tap-counter phase.
module coeffs_load_sequencer #(
    parameter int unsigned NUM_COEFFS  = 64,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned SYNC_COUNT  = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_enable,
    input  logic [ADDR_WIDTH-1:0]  current_count,
    input  logic                   load_start,
    input  logic                   load_abort,
    input  logic [COEFF_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [ADDR_WIDTH-1:0]  write_address,
    output logic [COEFF_WIDTH-1:0] coeffs_in,
    output logic                   write_enable,
    output logic                   coeffs_en,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    // One extra bit so the beat counter can reach NUM_COEFFS without wrapping.
    localparam int unsigned            CntWidth = ADDR_WIDTH + 1;
    localparam logic [CntWidth-1:0]    LastIdx  = CntWidth'(NUM_COEFFS - 1);
    localparam logic [ADDR_WIDTH-1:0]  SyncVal  = ADDR_WIDTH'(SYNC_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitSync,
        StCommit
    } state_e;

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COEFF_WIDTH-1:0] data_q, data_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   final_q, final_d;   // the frame's closing beat has been accepted
    logic                   bad_q, bad_d;       // that closing beat violated framing

    logic accept;
    logic consume;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        error_d = error_q;
        final_d = final_q;
        bad_d   = bad_q;
        s_ready = 1'b0;
        accept  = 1'b0;
        consume = we_q && clk_enable;

        case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    final_d = 1'b0;
                    bad_d   = 1'b0;
                end
            end
            StLoad: begin
                s_ready = !final_q && (!we_q || clk_enable);
                accept  = s_valid && s_ready;
                if (load_abort) begin
                    state_d = StIdle;
                    we_d    = 1'b0;
                end else if (accept) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[ADDR_WIDTH-1:0];
                    data_d = s_data;
                    cnt_d  = cnt_q + 1'b1;
                    if (s_last || (cnt_q == LastIdx)) begin
                        final_d = 1'b1;
                        bad_d   = !(s_last && (cnt_q == LastIdx));
                    end
                end else if (consume) begin
                    we_d = 1'b0;
                    if (final_q) begin
                        if (bad_q) begin
                            state_d = StIdle;
                            error_d = 1'b1;
                        end else begin
                            state_d = StWaitSync;
                        end
                    end
                end
            end
            StWaitSync: begin
                if (load_abort) begin
                    state_d = StIdle;
                end else if (clk_enable && (current_count == SyncVal)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            final_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            error_q <= error_d;
            final_q <= final_d;
            bad_q   <= bad_d;
        end
    end

    assign write_address = addr_q;
    assign coeffs_in     = data_q;
    assign write_enable  = we_q;
    assign coeffs_en     = (state_q == StCommit);
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_coeffs_load_sequencer.sv
// Randomized self-checking bench for coeffs_load_sequencer: expected bank writes and commit timing
// come from a frame-level model of the reload protocol.
module tb_coeffs_load_sequencer;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic [5:0]  current_count = '0;
    logic        load_start = 1'b0;
    logic        load_abort = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [5:0]  write_address;
    logic [15:0] coeffs_in;
    logic        write_enable;
    logic        coeffs_en;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;

    logic       cc_hold = 1'b0;
    logic [5:0] cc_hold_val = '0;

    // Observed bank writes and event timestamps (negedge cycle index).
    logic [21:0] wq[$];
    logic [21:0] exp_q[$];
    int cyc = 0;
    int last_wr_cyc = 0;
    int last_wr_cc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int en_prev_cc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [5:0] prev_cc = '0;

    coeffs_load_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .clk_enable    (clk_enable),
        .current_count (current_count),
        .load_start    (load_start),
        .load_abort    (load_abort),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .write_address (write_address),
        .coeffs_in     (coeffs_in),
        .write_enable  (write_enable),
        .coeffs_en     (coeffs_en),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Tap counter advances on enabled cycles, or is pinned while cc_hold is set.
    always @(posedge clk) begin
        #1;
        if (cc_hold) current_count <= cc_hold_val;
        else if (clk_enable) current_count <= current_count + 6'd1;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst && write_enable && clk_enable) begin
            wq.push_back({write_address, coeffs_in});
            last_wr_cyc <= cyc;
            last_wr_cc  <= int'(current_count);
        end
        if (coeffs_en) begin
            en_cnt     <= en_cnt + 1;
            en_cyc     <= cyc;
            en_prev_cc <= int'(prev_cc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        prev_cc <= current_count;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    // Offer beats k0..n-1; records each accepted beat as an expected write.
    task automatic send_frame(input int k0, input int n, input int last_at, input bit rnd,
                              input bit poke, input bit ramp);
        int k;
        int guard;
        logic [15:0] d;
        k = k0;
        guard = 0;
        d = ramp ? 16'(3 * k) : 16'($urandom);
        while (k < n && guard < 4000) begin
            s_valid    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data     = d;
            s_last     = (k == last_at);
            clk_enable = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            load_start = poke && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (s_valid && s_ready) begin
                exp_q.push_back({6'(k), d});
                k++;
                d = ramp ? 16'(3 * k) : 16'($urandom);
            end
            tick();
            guard++;
        end
        s_valid    = 1'b0;
        s_last     = 1'b0;
        load_start = 1'b0;
        clk_enable = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        total++;
        if ({s_ready, write_enable, coeffs_en, busy, done, error} !== 6'b0)
            $display("FAIL reset_ctrl: got=%b want=000000",
                     {s_ready, write_enable, coeffs_en, busy, done, error});
        total++;
        if (write_address !== 6'd0) $display("FAIL reset_addr: got=%0d want=0", write_address);
        total++;
        if (coeffs_in !== 16'd0) $display("FAIL reset_data: got=%0d want=0", coeffs_in);
        if ({s_ready, write_enable, coeffs_en, busy, done, error} !== 6'b0) bad++;
        if (write_address !== 6'd0) bad++;
        if (coeffs_in !== 16'd0) bad++;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({s_ready, busy} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got=%b want=00", {s_ready, busy});
        end
        tick();
    endtask

    task automatic test_full_load();
        int wb, e0, d0, exp_en;
        bit ok;
        exp_q.delete();
        wb = wq.size(); e0 = en_cnt; d0 = done_cnt;
        start_load();
        send_frame(0, N, N - 1, 1'b0, 1'b0, 1'b1);
        wait_idle(300, ok);
        repeat (2) tick();
        total++;
        if (!ok) begin bad++; $display("FAIL full_timeout: got=busy want=idle"); end
        total++;
        if (wq.size() - wb !== N) begin
            bad++; $display("FAIL full_nwrites: got=%0d want=%0d", wq.size() - wb, N);
        end
        for (int i = 0; i < exp_q.size() && wb + i < wq.size(); i++) begin
            total++;
            if (wq[wb+i] !== exp_q[i]) begin
                bad++; $display("FAIL full_write[%0d]: got=%h want=%h", i, wq[wb+i], exp_q[i]);
            end
        end
        // Commit fires the cycle after the tap counter first reads 63 once waiting for sync.
        exp_en = last_wr_cyc + 2 + ((62 - last_wr_cc) % 64 + 64) % 64;
        total++;
        if (en_cnt - e0 !== 1) begin
            bad++; $display("FAIL full_en_count: got=%0d want=1", en_cnt - e0);
        end
        total++;
        if (en_cyc !== exp_en) begin
            bad++; $display("FAIL full_en_cycle: got=%0d want=%0d", en_cyc, exp_en);
        end
        total++;
        if (done_cnt - d0 !== 1 || done_cyc !== en_cyc + 1) begin
            bad++; $display("FAIL full_done: got=%0d@%0d want=1@%0d", done_cnt - d0, done_cyc,
                            en_cyc + 1);
        end
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL full_error: got=%b want=0", error); end
    endtask

    task automatic test_clk_stall();
        int wb, e0;
        bit ok;
        exp_q.delete();
        wb = wq.size(); e0 = en_cnt;
        start_load();
        send_frame(0, 21, -1, 1'b0, 1'b0, 1'b1);
        clk_enable = 1'b0; s_valid = 1'b1; s_data = 16'(3 * 21); s_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            total++;
            if ({write_enable, s_ready} !== 2'b10) begin
                bad++; $display("FAIL stall_hs: got=%b want=10", {write_enable, s_ready});
            end
            total++;
            if (write_address !== 6'd20 || coeffs_in !== 16'd60) begin
                bad++; $display("FAIL stall_hold: got=%0d/%0d want=20/60", write_address, coeffs_in);
            end
            tick();
        end
        send_frame(21, N, N - 1, 1'b0, 1'b0, 1'b1);
        wait_idle(300, ok);
        repeat (2) tick();
        total++;
        if (wq.size() - wb !== N) begin
            bad++; $display("FAIL stall_nwrites: got=%0d want=%0d", wq.size() - wb, N);
        end
        for (int i = 0; i < exp_q.size() && wb + i < wq.size(); i++) begin
            total++;
            if (wq[wb+i] !== exp_q[i]) begin
                bad++; $display("FAIL stall_write[%0d]: got=%h want=%h", i, wq[wb+i], exp_q[i]);
            end
        end
        total++;
        if (en_cnt - e0 !== 1 || error !== 1'b0) begin
            bad++; $display("FAIL stall_commit: got=%0d/%b want=1/0", en_cnt - e0, error);
        end
    endtask

    task automatic test_random();
        int wb, e0;
        bit ok;
        for (int rep = 0; rep < 2; rep++) begin
            exp_q.delete();
            wb = wq.size(); e0 = en_cnt;
            start_load();
            send_frame(0, N, N - 1, 1'b1, 1'b1, 1'b0);
            wait_idle(400, ok);
            repeat (2) tick();
            total++;
            if (wq.size() - wb !== N) begin
                bad++; $display("FAIL rand_nwrites: got=%0d want=%0d", wq.size() - wb, N);
            end
            for (int i = 0; i < exp_q.size() && wb + i < wq.size(); i++) begin
                total++;
                if (wq[wb+i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand_write[%0d]: got=%h want=%h", i, wq[wb+i], exp_q[i]);
                end
            end
            total++;
            if (en_cnt - e0 !== 1 || en_prev_cc !== 63) begin
                bad++; $display("FAIL rand_commit: got=%0d@cc%0d want=1@cc63", en_cnt - e0,
                                en_prev_cc);
            end
            total++;
            if (error !== 1'b0) begin bad++; $display("FAIL rand_error: got=%b want=0", error); end
        end
    endtask

    task automatic test_short_frame();
        int wb, e0;
        bit ok;
        exp_q.delete();
        wb = wq.size(); e0 = en_cnt;
        start_load();
        send_frame(0, 10, 9, 1'b0, 1'b0, 1'b1);
        wait_idle(50, ok);
        repeat (70) tick();
        total++;
        if (!ok || wq.size() - wb !== 10) begin
            bad++; $display("FAIL short_nwrites: got=%0d want=10", wq.size() - wb);
        end
        for (int i = 0; i < exp_q.size() && wb + i < wq.size(); i++) begin
            total++;
            if (wq[wb+i] !== exp_q[i]) begin
                bad++; $display("FAIL short_write[%0d]: got=%h want=%h", i, wq[wb+i], exp_q[i]);
            end
        end
        total++;
        if ({error, busy} !== 2'b10 || en_cnt - e0 !== 0) begin
            bad++; $display("FAIL short_err: got=%b%b en=%0d want=10 en=0", error, busy,
                            en_cnt - e0);
        end
        start_load();
        @(negedge clk);
        total++;
        if ({error, busy} !== 2'b01) begin
            bad++; $display("FAIL short_clear: got=%b want=01", {error, busy});
        end
        tick();
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        @(negedge clk);
        total++;
        if ({error, busy} !== 2'b00) begin
            bad++; $display("FAIL short_abort: got=%b want=00", {error, busy});
        end
        tick();
    endtask

    task automatic test_missing_last();
        int wb, e0;
        bit ok;
        exp_q.delete();
        wb = wq.size(); e0 = en_cnt;
        start_load();
        send_frame(0, N, -1, 1'b0, 1'b0, 1'b1);
        wait_idle(50, ok);
        repeat (70) tick();
        total++;
        if (!ok || wq.size() - wb !== N) begin
            bad++; $display("FAIL nolast_nwrites: got=%0d want=%0d", wq.size() - wb, N);
        end
        total++;
        if ({error, busy} !== 2'b10 || en_cnt - e0 !== 0) begin
            bad++; $display("FAIL nolast_err: got=%b%b en=%0d want=10 en=0", error, busy,
                            en_cnt - e0);
        end
    endtask

    task automatic test_abort();
        int e0, d0;
        e0 = en_cnt; d0 = done_cnt;
        exp_q.delete();
        cc_hold_val = 6'd0;
        cc_hold = 1'b1;
        start_load();
        send_frame(0, N, N - 1, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        cc_hold_val = 6'd40;
        repeat (2) tick();
        @(negedge clk);
        total++;
        if ({busy, write_enable} !== 2'b10) begin
            bad++; $display("FAIL abort_waitsync: got=%b want=10", {busy, write_enable});
        end
        tick();
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, write_enable, coeffs_en} !== 3'b000) begin
            bad++; $display("FAIL abort_idle: got=%b want=000", {busy, write_enable, coeffs_en});
        end
        tick();
        cc_hold = 1'b0;
        repeat (80) tick();
        total++;
        if (en_cnt - e0 !== 0 || done_cnt - d0 !== 0 || error !== 1'b0) begin
            bad++; $display("FAIL abort_nocommit: got=en%0d done%0d err%b want=en0 done0 err0",
                            en_cnt - e0, done_cnt - d0, error);
        end
        // Abort while a write is stalled in the bank port.
        start_load();
        send_frame(0, 10, -1, 1'b0, 1'b0, 1'b1);
        clk_enable = 1'b0;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, write_enable} !== 2'b00) begin
            bad++; $display("FAIL abort_load: got=%b want=00", {busy, write_enable});
        end
        tick();
        clk_enable = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        int wb, e0;
        bit ok;
        start_load();
        send_frame(0, 30, -1, 1'b0, 1'b0, 1'b1);
        #3 rst = 1'b0;
        #1;
        total++;
        if ({s_ready, write_enable, coeffs_en, busy, done, error} !== 6'b0 ||
            write_address !== 6'd0 || coeffs_in !== 16'd0) begin
            bad++; $display("FAIL midreset: got=%b a=%0d d=%0d want=000000 a=0 d=0",
                            {s_ready, write_enable, coeffs_en, busy, done, error},
                            write_address, coeffs_in);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        wb = wq.size(); e0 = en_cnt;
        start_load();
        send_frame(0, N, N - 1, 1'b0, 1'b0, 1'b1);
        wait_idle(300, ok);
        repeat (2) tick();
        total++;
        if (wq.size() - wb !== N) begin
            bad++; $display("FAIL post_reset_nwrites: got=%0d want=%0d", wq.size() - wb, N);
        end
        for (int i = 0; i < exp_q.size() && wb + i < wq.size(); i++) begin
            total++;
            if (wq[wb+i] !== exp_q[i]) begin
                bad++; $display("FAIL post_reset_write[%0d]: got=%h want=%h", i, wq[wb+i],
                                exp_q[i]);
            end
        end
        total++;
        if (en_cnt - e0 !== 1 || error !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_commit: got=en%0d err%b busy%b want=en1 err0 busy0",
                            en_cnt - e0, error, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_clk_stall();
        test_random();
        test_short_frame();
        test_missing_last();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
